// File: rtl/nn_demo_io_ctrl.sv
// nn_demo_io_ctrl: board-side I/O controller for the neural-network demo.
// Turns the raw start key into a debounced start pulse, produces the
// clock-enable tick the core runs on, sequences runs with a watchdog,
// latches the argmax class, counts completed runs, and drives LEDs and a
// multi-digit active-low 7-segment display.
//
// Build option: define NN_DEMO_LED_BAR_EN to show nn_state as a thermometer
// bar on ledr instead of a one-hot position.
//
// Core interface timing: tick is a one-clk enable every DIV clks. All
// control towards the core (start_pulse) changes only on tick edges and is
// held for a full tick period, so the core samples it exactly once on its
// next tick. nn_done is a level that is only acted on at tick edges.
module nn_demo_io_ctrl #(
   parameter int DIV            = 8,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int TIMEOUT_TICKS  = 1024,
   parameter int STATE_W        = 4,
   parameter int CLASS_W        = 4,
   parameter int NUM_DIGITS     = 3,
   parameter int LED_W          = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    key_n,
   input  logic                    nn_done,
   input  logic [STATE_W-1:0]      nn_state,
   input  logic [CLASS_W-1:0]      nn_argmax,
   output logic                    tick,
   output logic                    start_pulse,
   output logic                    busy,
   output logic [LED_W-1:0]        ledr,
   output logic [7*NUM_DIGITS-1:0] hex
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
   localparam int CNT_W = 4 * (NUM_DIGITS - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_ERR   = 7'b0000110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SHOW  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [DIV_W-1:0]   div_cnt;
   logic               key_s1;
   logic               key_s2;
   logic               key_acc;
   logic [DB_W-1:0]    db_cnt;
   logic               press_evt;
   logic [WD_W-1:0]    wd_cnt;
   logic [CLASS_W-1:0] class_q;
   logic [CNT_W-1:0]   run_count;
   logic               do_start;
   logic               do_latch;
   logic               wd_clr;
   logic               wd_inc;
   logic               busy_d;
   logic [LED_W-1:0]   led_d;
   logic [7*NUM_DIGITS-1:0] hex_d;
   logic [3:0]         class_nib;

   // Active-low hex digit patterns, segment order gfedcba.
   function automatic logic [6:0] seg_hex(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Tick divider: counter 0..DIV-1; tick is registered so it is high
   // exactly while the counter sits at DIV-1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         tick <= (div_cnt == DIV_W'(DIV - 2));
      end
   end

   // Two-flop synchroniser; idles at the released (high) key level.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   // Debounce: a level differing from the accepted one must persist for
   // DEBOUNCE_TICKS ticks. A press is held pending until the next tick,
   // where the FSM consumes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_cnt    <= '0;
         key_acc   <= 1'b1;
         press_evt <= 1'b0;
      end else begin
         if (tick) begin
            press_evt <= 1'b0;
         end
         if (key_s2 == key_acc) begin
            db_cnt <= '0;
         end else if (tick) begin
            if (db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
               db_cnt  <= '0;
               key_acc <= key_s2;
               if (!key_s2) begin
                  press_evt <= 1'b1;
               end
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end
      end
   end

   // Run sequencer next-state logic; every decision is taken on a tick.
   always_comb begin
      state_d  = state_q;
      do_start = 1'b0;
      do_latch = 1'b0;
      wd_clr   = 1'b0;
      wd_inc   = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE, ST_SHOW, ST_ERROR: begin
               if (press_evt) begin
                  state_d  = ST_RUN;
                  do_start = 1'b1;
                  wd_clr   = 1'b1;
               end
            end
            ST_RUN: begin
               // done takes priority over a coincident timeout
               if (nn_done) begin
                  state_d  = ST_SHOW;
                  do_latch = 1'b1;
               end else begin
                  wd_inc = 1'b1;
                  if (wd_cnt == WD_W'(TIMEOUT_TICKS - 1)) begin
                     state_d = ST_ERROR;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Sequencer state, watchdog, class latch, run counter and start pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         wd_cnt      <= '0;
         class_q     <= '0;
         run_count   <= '0;
         start_pulse <= 1'b0;
      end else begin
         state_q <= state_d;
         if (wd_clr) begin
            wd_cnt <= '0;
         end else if (wd_inc) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
         if (do_latch) begin
            class_q   <= nn_argmax;
            run_count <= run_count + CNT_W'(1);
         end
         if (tick) begin
            start_pulse <= do_start;
         end
      end
   end

   assign class_nib = 4'(class_q);

   // Next values for the registered busy, LED and display outputs.
   always_comb begin
      busy_d = (state_q == ST_RUN);
      led_d  = '0;
      hex_d  = '1;
      for (int i = 0; i < LED_W; i++) begin
`ifdef NN_DEMO_LED_BAR_EN
         led_d[i] = (32'(nn_state) >= 32'(i));
`else
         led_d[i] = (32'(nn_state) == 32'(i));
`endif
      end
      if (state_q == ST_ERROR) begin
         led_d[LED_W-1] = 1'b1;
      end
      case (state_q)
         ST_IDLE:  hex_d[6:0] = SEG_BLANK;
         ST_ERROR: hex_d[6:0] = SEG_ERR;
         default:  hex_d[6:0] = (32'(class_q) > 32'd9) ? SEG_DASH : seg_hex(class_nib);
      endcase
      for (int k = 1; k < NUM_DIGITS; k++) begin
         hex_d[7*k +: 7] = seg_hex(run_count[4*(k-1) +: 4]);
      end
   end

   // Output registers; display blanks and LEDs go dark in reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy <= 1'b0;
         ledr <= '0;
         hex  <= '1;
      end else begin
         busy <= busy_d;
         ledr <= led_d;
         hex  <= hex_d;
      end
   end

endmodule

// File: tb/tb_nn_demo_io_ctrl.sv
// tb_nn_demo_io_ctrl: directed bench for nn_demo_io_ctrl (default build).
// Stimulus pushes the expected {busy, ledr, hex} word for every output
// change it is about to cause, and the expected width of every start pulse;
// independent monitors pop and compare when the DUT outputs change.
module tb_nn_demo_io_ctrl;

   localparam int DIV  = 8;
   localparam int DBT  = 4;
   localparam int TMO  = 16;
   localparam int SW   = 4;
   localparam int CW   = 4;
   localparam int ND   = 3;
   localparam int LW   = 10;
   localparam int OBSW = 1 + LW + 7 * ND;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] ESEG  = 7'b0000110;
   localparam logic [OBSW-1:0] RESET_OBS = {1'b0, {LW{1'b0}}, {(7*ND){1'b1}}};

   logic              clk;
   logic              resetn;
   logic              key_n;
   logic              nn_done;
   logic [SW-1:0]     nn_state;
   logic [CW-1:0]     nn_argmax;
   logic              tick;
   logic              start_pulse;
   logic              busy;
   logic [LW-1:0]     ledr;
   logic [7*ND-1:0]   hex;

   logic [OBSW-1:0]   exp_q[$];
   logic [7:0]        start_q[$];
   int                n_vec;
   int                n_err;

   nn_demo_io_ctrl #(
      .DIV(DIV), .DEBOUNCE_TICKS(DBT), .TIMEOUT_TICKS(TMO), .STATE_W(SW),
      .CLASS_W(CW), .NUM_DIGITS(ND), .LED_W(LW)
   ) dut (
      .clk(clk), .resetn(resetn), .key_n(key_n), .nn_done(nn_done),
      .nn_state(nn_state), .nn_argmax(nn_argmax), .tick(tick),
      .start_pulse(start_pulse), .busy(busy), .ledr(ledr), .hex(hex)
   );

   // Clock and global time bound.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 3000000");
      $fatal(1);
   end

   function automatic logic [6:0] seg(input int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [6:0] cls_seg(input int c);
      return (c > 9) ? DASH : seg(c);
   endfunction

   function automatic logic [OBSW-1:0] mk_obs(input logic b, input logic [LW-1:0] l,
                                              input logic [6:0] d2, input logic [6:0] d1,
                                              input logic [6:0] d0);
      return {b, l, d2, d1, d0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Return just after the next tick edge; bounded so a dead tick cannot hang.
   task automatic wait_tick();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!tick && guard < 4 * DIV);
      if (!tick) begin
         n_vec++;
         n_err++;
         $display("FAIL tick_wait: no tick within %0d clks, expected one every %0d", 4 * DIV, DIV);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) wait_tick();
   endtask

   task automatic press_key(input int lo, input int hi);
      key_n = 1'b0;
      wait_ticks(lo);
      key_n = 1'b1;
      wait_ticks(hi);
   endtask

   // Output monitor: every change of {busy, ledr, hex} must match the next expected word.
   initial begin
      logic [OBSW-1:0] prev;
      logic [OBSW-1:0] obs;
      logic [OBSW-1:0] e;
      prev = RESET_OBS;
      forever begin
         @(negedge clk);
         obs = {busy, ledr, hex};
         if (obs != prev) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL out_change: got %h, expected no change from %h", obs, prev);
            end else begin
               e = exp_q.pop_front();
               if (obs != e) begin
                  n_err++;
                  $display("FAIL out_change: got %h, expected %h", obs, e);
               end
            end
            prev = obs;
         end
      end
   end

   // Start-pulse monitor: each completed pulse must match the next expected width.
   initial begin
      int w;
      logic [7:0] e;
      w = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            w = 0;
         end else if (start_pulse) begin
            w++;
         end else if (w > 0) begin
            n_vec++;
            if (start_q.size() == 0) begin
               n_err++;
               $display("FAIL start_pulse: got pulse of %0d clks, expected none", w);
            end else begin
               e = start_q.pop_front();
               if (8'(w) != e) begin
                  n_err++;
                  $display("FAIL start_width: got %0d clks, expected %0d", w, e);
               end
            end
            w = 0;
         end
      end
   end

   // Directed stimulus.
   initial begin
      int cls_prev;
      int cls;
      n_vec = 0;
      n_err = 0;
      resetn = 1'b1;
      key_n = 1'b1;
      nn_done = 1'b0;
      nn_state = '0;
      nn_argmax = '0;

      // Reset values (asynchronous, before any clock edge)
      #1 resetn = 1'b0;
      #1;
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_start", 32'(start_pulse), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ledr", 32'(ledr), 32'd0);
      check("rst_hex", 32'(hex), 32'h1FFFFF);

      // After release: count 00 on digits 1..2, class digit blank, ledr one-hot bit 0
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(0), BLANK));
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Tick high only in the cycle after edge 7, 15, 23, ...
      for (int e = 1; e <= 4 * DIV; e++) begin
         @(posedge clk);
         #1;
         check("tick_phase", 32'(tick), (e % DIV == DIV - 1) ? 32'd1 : 32'd0);
      end

      // ledr follows nn_state one-hot; out-of-range state gives 0
      exp_q.push_back(mk_obs(1'b0, 10'h008, seg(0), seg(0), BLANK));
      nn_state = 4'd3;
      repeat (4) @(posedge clk);
      exp_q.push_back(mk_obs(1'b0, 10'h000, seg(0), seg(0), BLANK));
      nn_state = 4'd12;
      repeat (4) @(posedge clk);
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(0), BLANK));
      nn_state = 4'd0;
      repeat (4) @(posedge clk);

      // Glitch of 2 ticks: no press, no output change, no start
      wait_tick();
      key_n = 1'b0;
      wait_ticks(2);
      key_n = 1'b1;
      wait_ticks(6);
      check("glitch_busy", 32'(busy), 32'd0);

      // Real press: RUN, one 8-clk start pulse, class digit shows latch 0
      exp_q.push_back(mk_obs(1'b1, 10'h001, seg(0), seg(0), seg(0)));
      start_q.push_back(8'd8);
      press_key(6, 6);
      check("run_busy", 32'(busy), 32'd1);

      // Done with class 7 -> SHOW, count 1
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(1), seg(7)));
      nn_argmax = 4'd7;
      nn_done = 1'b1;
      wait_tick();
      nn_done = 1'b0;

      // New run from SHOW, then watchdog expiry after 16 ticks in RUN
      exp_q.push_back(mk_obs(1'b1, 10'h001, seg(0), seg(1), seg(7)));
      start_q.push_back(8'd8);
      press_key(6, 6);
      exp_q.push_back(mk_obs(1'b0, 10'h201, seg(0), seg(1), ESEG));
      wait_ticks(8);
      check("wd_tick15_busy", 32'(busy), 32'd1);
      wait_tick();
      @(posedge clk);
      #1;
      check("wd_tick16_busy", 32'(busy), 32'd0);
      check("err_hex0", 32'(hex[6:0]), 32'(ESEG));
      check("err_ledr9", 32'(ledr[LW-1]), 32'd1);

      // Press from ERROR -> RUN with count unchanged; then done with class 12 -> dash
      wait_tick();
      exp_q.push_back(mk_obs(1'b1, 10'h001, seg(0), seg(1), seg(7)));
      start_q.push_back(8'd8);
      press_key(6, 6);
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(2), DASH));
      nn_argmax = 4'd12;
      nn_done = 1'b1;
      wait_tick();
      nn_done = 1'b0;

      // Done and timeout on the same tick: done wins
      exp_q.push_back(mk_obs(1'b1, 10'h001, seg(0), seg(2), DASH));
      start_q.push_back(8'd8);
      press_key(6, 6);
      wait_ticks(8);
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(3), seg(9)));
      nn_argmax = 4'd9;
      nn_done = 1'b1;
      wait_tick();
      nn_done = 1'b0;

      // Runs 4..256 with done held high: count wraps to 00
      cls_prev = 9;
      nn_done = 1'b1;
      for (int r = 4; r <= 256; r++) begin
         cls = (r + 5) % 16;
         nn_argmax = 4'(cls);
         exp_q.push_back(mk_obs(1'b1, 10'h001, seg(((r - 1) >> 4) & 15), seg((r - 1) & 15),
                                cls_seg(cls_prev)));
         exp_q.push_back(mk_obs(1'b0, 10'h001, seg((r >> 4) & 15), seg(r & 15), cls_seg(cls)));
         start_q.push_back(8'd8);
         press_key(5, 5);
         cls_prev = cls;
      end
      nn_done = 1'b0;
      check("wrap_hex", 32'(hex), 32'({seg(0), seg(0), seg(5)}));

      // Asynchronous reset in the middle of RUN, while start_pulse is high
      exp_q.push_back(mk_obs(1'b1, 10'h001, seg(0), seg(0), seg(5)));
      key_n = 1'b0;
      wait_ticks(5);
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_start", 32'(start_pulse), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      exp_q.push_back(RESET_OBS);
      resetn = 1'b0;
      #1;
      check("async_rst_start", 32'(start_pulse), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_ledr", 32'(ledr), 32'd0);
      check("async_rst_hex", 32'(hex), 32'h1FFFFF);
      check("async_rst_tick", 32'(tick), 32'd0);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
      exp_q.push_back(mk_obs(1'b0, 10'h001, seg(0), seg(0), BLANK));
      resetn = 1'b1;
      wait_ticks(8);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("start_q_drained", 32'(start_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
